// File: rtl/bcd_tick_counter.sv
// Prescaled multi-digit packed-BCD up/down counter, modulo MODULO, with clear, load and carry.
// Optional alarm comparator is enabled by defining BCD_TICK_ALARM_EN.
module bcd_tick_counter #(
  parameter int CLK_HZ  = 24_000_000,
  parameter int TICK_HZ = 1,
  parameter int DIGITS  = 2,
  parameter int MODULO  = 60
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  en_i,
  input  logic                  up_i,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
`ifdef BCD_TICK_ALARM_EN
  input  logic [4*DIGITS-1:0]   alarm_val_i,
  output logic                  alarm_o,
`endif
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  tick_o,
  output logic                  carry_o,
  output logic                  load_err_o
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW    = 4 * DIGITS;

  function automatic logic [CW-1:0] to_bcd(input int value);
    logic [CW-1:0] r;
    int            v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [CW-1:0] MAX_BCD = to_bcd(MODULO - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  // Decimal increment: ripple a carry through the digits while they roll 9 -> 0.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // For well-formed BCD, unsigned compare of the packed words equals decimal compare.
  function automatic logic bcd_valid(input logic [CW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    if (v > MAX_BCD) ok = 1'b0;
    return ok;
  endfunction

  logic [PRE_W-1:0] pre_cnt_q,  pre_cnt_d;
  logic [CW-1:0]    count_q,    count_d;
  logic             tick_q,     tick_d;
  logic             carry_q,    carry_d;
  logic             load_err_q, load_err_d;
  logic             written;
  logic             load_ok;

  assign load_ok = bcd_valid(load_val_i);

  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    count_d    = count_q;
    tick_d     = 1'b0;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    written    = 1'b0;
    if (clr_i) begin
      pre_cnt_d = '0;
      count_d   = '0;
      written   = 1'b1;
    end else if (load_i) begin
      // A rejected load freezes everything, including a coincident tick.
      if (load_ok) begin
        pre_cnt_d = '0;
        count_d   = load_val_i;
        written   = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en_i) begin
      if (pre_cnt_q == PRE_LAST) begin
        pre_cnt_d = '0;
        tick_d    = 1'b1;
        written   = 1'b1;
        if (up_i) begin
          if (count_q == MAX_BCD) begin
            count_d = '0;
            carry_d = 1'b1;
          end else begin
            count_d = bcd_inc(count_q);
          end
        end else begin
          if (count_q == '0) begin
            count_d = MAX_BCD;
            carry_d = 1'b1;
          end else begin
            count_d = bcd_dec(count_q);
          end
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      pre_cnt_q  <= '0;
      count_q    <= '0;
      tick_q     <= 1'b0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign count_o    = count_q;
  assign tick_o     = tick_q;
  assign carry_o    = carry_q;
  assign load_err_o = load_err_q;

`ifdef BCD_TICK_ALARM_EN
  logic alarm_q, alarm_d;

  // Only fires when the count is rewritten, so a static match stays quiet.
  always_comb begin
    alarm_d = written && (count_d == alarm_val_i);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm_o = alarm_q;
`else
  logic unused_written;
  assign unused_written = written;
`endif

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter (DIV=10, two digits, modulo 60): directed scenarios then
// randomized traffic, every cycle compared against a decimal-integer reference model.
module tb_bcd_tick_counter;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DIGITS  = 2;
  localparam int MOD     = 60;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       en_i = 1'b0;
  logic       up_i = 1'b1;
  logic       clr_i = 1'b0;
  logic       load_i = 1'b0;
  logic [7:0] load_val_i = 8'h00;
  logic [7:0] count_o;
  logic       tick_o;
  logic       carry_o;
  logic       load_err_o;
`ifdef BCD_TICK_ALARM_EN
  logic [7:0] alarm_val_i = 8'h03;
  logic       alarm_o;
  logic       m_alarm;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: plain decimal count and prescaler phase.
  int   m_cnt = 0;
  int   m_pre = 0;
  logic m_tick = 0, m_carry = 0, m_err = 0;

  bcd_tick_counter #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS), .MODULO(MOD)
  ) dut (
    .clk(clk), .res(res), .en_i(en_i), .up_i(up_i), .clr_i(clr_i),
    .load_i(load_i), .load_val_i(load_val_i),
`ifdef BCD_TICK_ALARM_EN
    .alarm_val_i(alarm_val_i), .alarm_o(alarm_o),
`endif
    .count_o(count_o), .tick_o(tick_o), .carry_o(carry_o), .load_err_o(load_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tobcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int   hi, lo;
    logic wr;
    m_tick = 0; m_carry = 0; m_err = 0; wr = 0;
    if (res) begin
      m_cnt = 0; m_pre = 0;
    end else if (clr_i) begin
      m_cnt = 0; m_pre = 0; wr = 1;
    end else if (load_i) begin
      hi = int'(load_val_i[7:4]);
      lo = int'(load_val_i[3:0]);
      if (hi <= 9 && lo <= 9 && hi * 10 + lo < MOD) begin
        m_cnt = hi * 10 + lo; m_pre = 0; wr = 1;
      end else begin
        m_err = 1;
      end
    end else if (en_i) begin
      m_pre++;
      if (m_pre == DIV) begin
        m_pre = 0; m_tick = 1; wr = 1;
        if (up_i) begin
          m_carry = (m_cnt == MOD - 1);
          m_cnt = (m_cnt + 1) % MOD;
        end else begin
          m_carry = (m_cnt == 0);
          m_cnt = (m_cnt + MOD - 1) % MOD;
        end
      end
    end
`ifdef BCD_TICK_ALARM_EN
    m_alarm = wr && (tobcd(m_cnt) == alarm_val_i);
`else
    if (wr) begin end
`endif
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".count"}, 32'(count_o), 32'(tobcd(m_cnt)));
    chk({tag, ".tick"}, 32'(tick_o), 32'(m_tick));
    chk({tag, ".carry"}, 32'(carry_o), 32'(m_carry));
    chk({tag, ".load_err"}, 32'(load_err_o), 32'(m_err));
`ifdef BCD_TICK_ALARM_EN
    chk({tag, ".alarm"}, 32'(alarm_o), 32'(m_alarm));
`endif
  endtask

  task automatic run_to_tick(input string tag, output int n);
    n = 0;
    do begin
      cyc(tag);
      n++;
    end while (tick_o !== 1'b1 && n < 20);
  endtask

  initial begin
    int         n;
    int         carries;
    logic [7:0] snap;

    // Reset state
    res = 1'b1;
    cyc("reset");
    chk("reset.count_zero", 32'(count_o), 32'h0);
    res = 1'b0; en_i = 1'b1; up_i = 1'b1;

    // Up-count through a full cycle with a single wrap carry
    run_to_tick("first", n);
    chk("first_tick_latency", n, DIV);
    chk("first_tick_count", 32'(count_o), 32'h01);
    carries = 0;
    for (int i = 0; i < MOD - 1; i++) begin
      run_to_tick("wrap", n);
      chk("tick_period", n, DIV);
      if (carry_o === 1'b1) carries++;
    end
    chk("wrap_count", 32'(count_o), 32'h00);
    chk("wrap_carries", carries, 1);

    // Digit carry up, digit borrow down, borrow wrap
    load_i = 1'b1; load_val_i = 8'h09;
    cyc("load09");
    load_i = 1'b0;
    run_to_tick("up09", n);
    chk("digit_carry", 32'(count_o), 32'h10);
    up_i = 1'b0;
    run_to_tick("dn10", n);
    chk("digit_borrow", 32'(count_o), 32'h09);
    load_i = 1'b1; load_val_i = 8'h00;
    cyc("load00");
    load_i = 1'b0;
    run_to_tick("dn00", n);
    chk("borrow_wrap_count", 32'(count_o), 32'h59);
    chk("borrow_wrap_carry", 32'(carry_o), 32'h1);

    // Freeze mid-period keeps count and remaining period
    up_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc("prefreeze");
    snap = count_o;
    en_i = 1'b0;
    for (int i = 0; i < 25; i++) begin
      up_i = (i % 2 == 0);
      cyc("freeze");
    end
    chk("freeze_count", 32'(count_o), 32'(snap));
    en_i = 1'b1; up_i = 1'b1;
    run_to_tick("resume", n);
    chk("resume_remaining", n, DIV - 4);

    // Valid and invalid loads
    load_i = 1'b1; load_val_i = 8'h45;
    cyc("load45");
    load_i = 1'b0;
    chk("load45_count", 32'(count_o), 32'h45);
    run_to_tick("after45", n);
    chk("after45_latency", n, DIV);
    chk("after45_count", 32'(count_o), 32'h46);
    load_i = 1'b1; load_val_i = 8'h6A;
    cyc("load6A");
    chk("load6A_err", 32'(load_err_o), 32'h1);
    chk("load6A_count", 32'(count_o), 32'h46);
    load_val_i = 8'h60;
    cyc("load60");
    chk("load60_err", 32'(load_err_o), 32'h1);
    chk("load60_count", 32'(count_o), 32'h46);
    load_i = 1'b0;
    cyc("err_pulse_end");

    // clr + load + tick on one edge, then reset mid-count
    load_i = 1'b1; load_val_i = 8'h20;
    cyc("load20");
    load_i = 1'b0;
    for (int i = 0; i < DIV - 1; i++) cyc("align");
    clr_i = 1'b1; load_i = 1'b1; load_val_i = 8'h33;
    cyc("clr_load_tick");
    chk("clr_collide_count", 32'(count_o), 32'h00);
    chk("clr_collide_tick", 32'(tick_o), 32'h0);
    clr_i = 1'b0; load_i = 1'b0;
    for (int i = 0; i < 37; i++) cyc("pre_res");
    res = 1'b1;
    cyc("mid_reset");
    chk("mid_reset_count", 32'(count_o), 32'h00);
    res = 1'b0;

`ifdef BCD_TICK_ALARM_EN
    // Alarm fires once on 02->03 and stays quiet while held
    alarm_val_i = 8'h03;
    load_i = 1'b1; load_val_i = 8'h02;
    cyc("load02");
    load_i = 1'b0;
    run_to_tick("alarm", n);
    chk("alarm_fire", 32'(alarm_o), 32'h1);
    en_i = 1'b0;
    for (int i = 0; i < 20; i++) cyc("alarm_hold");
    chk("alarm_quiet", 32'(alarm_o), 32'h0);
    en_i = 1'b1;
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      res        = ($urandom_range(0, 199) == 0);
      clr_i      = ($urandom_range(0, 59) == 0);
      load_i     = ($urandom_range(0, 24) == 0);
      load_val_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : tobcd($urandom_range(0, MOD - 1));
      en_i       = ($urandom_range(0, 9) != 0);
      up_i       = 1'($urandom);
`ifdef BCD_TICK_ALARM_EN
      if ($urandom_range(0, 99) == 0) alarm_val_i = tobcd($urandom_range(0, MOD - 1));
`endif
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
